dram_block_adapter: RTL
=======================

DRAM_BLOCK_ADAPTER -- requirements
Module: dram_block_adapter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, byte-address width.
REQ-002 SHALL have parameter BLOCK_BITS, default 512, L2 block width in bits.
REQ-003 SHALL have parameter SUBBLOCKS, default 4, power of two, memory beats per block; SUB_BITS=BLOCK_BITS/SUBBLOCKS, STB_BITS=log2(SUBBLOCKS).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache request present.
- req_ready  out  1  adapter accepts request this cycle.
- req_we  in  1  1=block write, 0=block read.
- req_addr  in  ADDR_BITS  byte address.
- req_wdata  in  BLOCK_BITS  write block.
- resp_valid  out  1  one-cycle completion pulse.
- resp_write  out  1  completion belongs to a write.
- resp_rdata  out  BLOCK_BITS  assembled read block.
- mem_addr  out  ADDR_BITS  block-aligned memory address.
- mem_en  out  1  read request pulse.
- mem_we  out  1  write beat strobe.
- mem_dinDstrobe  out  STB_BITS  index of write beat.
- mem_din  out  SUB_BITS  write beat data.
- mem_doutDstrobe  in  STB_BITS  index of read beat.
- mem_dout  in  SUB_BITS  read beat data.
- mem_dready  in  1  read beat valid.
- mem_accR  in  1  memory can accept a read.
- mem_accW  in  1  memory can accept a write.

Function
REQ-005 SHALL implement states IDLE, WWAIT, WBURST, RWAIT_ACC, RCOLLECT, RESP; all mem_* and resp_* outputs registered.
REQ-006 req_ready SHALL equal (state==IDLE) and reset high; handshake = req_valid&&req_ready; req_valid in other states ignored, no state change.
REQ-007 On handshake SHALL latch req_we, req_wdata, req_addr with low log2(BLOCK_BITS/8) bits cleared; next state WWAIT if write, RWAIT_ACC if read.
REQ-008 mem_addr SHALL be driven with the latched aligned address from the cycle after handshake until leaving RCOLLECT/WBURST, unchanged.
REQ-009 WWAIT: wait until mem_accW==1 sampled; then WBURST.
REQ-010 WBURST: mem_we=1 for exactly SUBBLOCKS consecutive cycles, mem_dinDstrobe=0,1,...,SUBBLOCKS-1, mem_din=latched bits [SUB_BITS*(k+1)-1 : SUB_BITS*k] for beat k; mem_en=0 throughout; then RESP with resp_write=1.
REQ-011 RWAIT_ACC: wait until mem_accR==1 sampled; then mem_en=1 for exactly one cycle, mem_we=0; enter RCOLLECT with received-mask cleared.
REQ-012 RCOLLECT: each cycle mem_dready==1, SHALL write mem_dout into block slot mem_doutDstrobe and set mask bit; beats accepted in any order; repeat index overwrites data, mask unchanged.
REQ-013 When mask is all ones (including beat arriving that cycle), SHALL go to RESP; resp_valid rises the cycle after final beat.
REQ-014 RESP: resp_valid=1 one cycle; resp_rdata=assembled block on read, holds last read value on write; then IDLE.
REQ-015 mem_dready outside RCOLLECT SHALL be ignored and not corrupt resp_rdata.
REQ-016 mem_we and mem_en SHALL never be 1 in the same cycle.
REQ-017 No timeout; adapter waits indefinitely for accR/accW/beats.

Reset
REQ-018 reset low SHALL immediately force state IDLE, mask 0, beat counter 0, and all outputs 0 (req_ready 0, resp_rdata 0, mem_addr 0), regardless of operation in progress.
REQ-019 After reset rises, req_ready SHALL be 1 with no pending memory activity; a burst interrupted by reset is abandoned, never resumed.

Verification (BLOCK_BITS=512, SUBBLOCKS=4)
REQ-020 Reset low 3 cycles mid-WBURST after beat 1 -> mem_we=0 instantly, all outputs 0; after release req_ready=1, no further beats.
REQ-021 Write req_addr=0x00010047, accW=1 -> mem_addr=0x00010040, mem_we high 4 consecutive cycles, strobes 0,1,2,3 with din=wdata[127:0],[255:128],[383:256],[511:384]; resp_valid=1, resp_write=1 next cycle.
REQ-022 Read with mem_accR=0 for 3 cycles then 1 -> mem_en stays 0 those cycles, then single mem_en pulse; mem_addr stable until resp_valid.
REQ-023 Read beats arrive strobes 2,0,3,1 with data 0xC..,0xA..,0xD..,0xB.. -> resp_rdata = {D,C,B,A} slots, resp_valid one cycle after strobe 1 beat.
REQ-024 req_valid held during RCOLLECT with different address -> req_ready=0, latched address unchanged; request accepted in IDLE after RESP.
REQ-025 mem_dready pulses while IDLE with strobe 0 data 0xFF.. -> resp_rdata unchanged, resp_valid stays 0.

Source files
------------

// File: rtl/dram_block_adapter.sv
// Adapts single-cycle L2 block requests onto a beat-oriented DRAM port:
// writes are streamed as SUBBLOCKS beats, reads are reassembled from beats arriving in any order.
module dram_block_adapter #(
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 512,
  parameter int SUBBLOCKS  = 4,
  localparam int SUB_BITS  = BLOCK_BITS / SUBBLOCKS,
  localparam int STB_BITS  = $clog2(SUBBLOCKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [BLOCK_BITS-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [BLOCK_BITS-1:0] resp_rdata,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [STB_BITS-1:0]   mem_dinDstrobe,
  output logic [SUB_BITS-1:0]   mem_din,
  input  logic [STB_BITS-1:0]   mem_doutDstrobe,
  input  logic [SUB_BITS-1:0]   mem_dout,
  input  logic                  mem_dready,
  input  logic                  mem_accR,
  input  logic                  mem_accW
);
  localparam int OFF_BITS = $clog2(BLOCK_BITS / 8);
  localparam logic [STB_BITS-1:0] LAST_BEAT = STB_BITS'(SUBBLOCKS - 1);

  typedef enum logic [2:0] {IDLE, WWAIT, WBURST, RWAIT_ACC, RCOLLECT, RESP} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_BITS-1:0]  addr_reg, addr_next;
  logic [BLOCK_BITS-1:0] data_reg, data_next;
  logic [STB_BITS-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [SUBBLOCKS-1:0]  mask_reg, mask_next, mask_merged;
  logic                  mem_we_reg, mem_we_next;
  logic                  mem_en_reg, mem_en_next;
  logic [STB_BITS-1:0]   stb_reg, stb_next;
  logic [SUB_BITS-1:0]   din_reg, din_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic                  resp_write_reg, resp_write_next;
  logic [BLOCK_BITS-1:0] rdata_reg, rdata_next;

  // The block buffer holds the write data on writes and collects beats on reads.
  logic [SUB_BITS-1:0]   slot [SUBBLOCKS];
  logic [BLOCK_BITS-1:0] merged;
  logic [SUBBLOCKS-1:0]  beat_bit;
  logic                  beat_in;

  assign beat_in = mem_dready && (state_reg == RCOLLECT);
  assign cnt_inc = cnt_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < SUBBLOCKS; gi++) begin : g_slot
      assign slot[gi]     = data_reg[gi*SUB_BITS +: SUB_BITS];
      assign beat_bit[gi] = beat_in && (mem_doutDstrobe == STB_BITS'(gi));
      assign merged[gi*SUB_BITS +: SUB_BITS] = beat_bit[gi] ? mem_dout : slot[gi];
    end
  endgenerate

  assign mask_merged = mask_reg | beat_bit;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    cnt_next        = cnt_reg;
    mask_next       = mask_reg;
    mem_we_next     = 1'b0;
    mem_en_next     = 1'b0;
    stb_next        = stb_reg;
    din_next        = din_reg;
    resp_valid_next = 1'b0;
    resp_write_next = resp_write_reg;
    rdata_next      = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next  = {req_addr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
          data_next  = req_wdata;
          state_next = req_we ? WWAIT : RWAIT_ACC;
        end
      end
      WWAIT: begin
        if (mem_accW) begin
          state_next  = WBURST;
          mem_we_next = 1'b1;
          cnt_next    = '0;
          stb_next    = '0;
          din_next    = slot[0];
        end
      end
      WBURST: begin
        // cnt_reg is the beat currently presented on mem_din.
        if (cnt_reg == LAST_BEAT) begin
          state_next      = RESP;
          cnt_next        = '0;
          resp_valid_next = 1'b1;
          resp_write_next = 1'b1;
        end else begin
          cnt_next    = cnt_inc;
          mem_we_next = 1'b1;
          stb_next    = cnt_inc;
          din_next    = slot[cnt_inc];
        end
      end
      RWAIT_ACC: begin
        if (mem_accR) begin
          state_next  = RCOLLECT;
          mem_en_next = 1'b1;
          mask_next   = '0;
        end
      end
      RCOLLECT: begin
        if (beat_in) begin
          data_next = merged;
          mask_next = mask_merged;
          if (&mask_merged) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_write_next = 1'b0;
            rdata_next      = merged;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
        mask_next  = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg       <= '0;
      data_reg       <= '0;
      cnt_reg        <= '0;
      mask_reg       <= '0;
      mem_we_reg     <= 1'b0;
      mem_en_reg     <= 1'b0;
      stb_reg        <= '0;
      din_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_write_reg <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      cnt_reg        <= cnt_next;
      mask_reg       <= mask_next;
      mem_we_reg     <= mem_we_next;
      mem_en_reg     <= mem_en_next;
      stb_reg        <= stb_next;
      din_reg        <= din_next;
      resp_valid_reg <= resp_valid_next;
      resp_write_reg <= resp_write_next;
      rdata_reg      <= rdata_next;
    end
  end

  // Gated by reset so the handshake is refused while reset is held.
  assign req_ready      = reset && (state_reg == IDLE);
  assign resp_valid     = resp_valid_reg;
  assign resp_write     = resp_write_reg;
  assign resp_rdata     = rdata_reg;
  assign mem_addr       = addr_reg;
  assign mem_en         = mem_en_reg;
  assign mem_we         = mem_we_reg;
  assign mem_dinDstrobe = stb_reg;
  assign mem_din        = din_reg;

endmodule
